// File: rtl/pc_ras.sv
// Program counter with an integrated circular return-address stack.
// One command executes per cycle by fixed priority; all outputs come straight from flops.
module pc_ras #(
  parameter int unsigned       ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       STEP      = 1,
  parameter int unsigned       RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              pc_inc,
  input  logic              write,
  input  logic [ADDR_W-1:0] wdata,
  input  logic              branch_rel,
  input  logic [ADDR_W-1:0] offset,
  input  logic              call,
  input  logic              ret,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  CntFull = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0]  CntZero = '0;
  localparam logic [ADDR_W-1:0] StepV   = ADDR_W'(STEP);

  // Declaration initialisers make the power-up state match the reset state in simulation.
  logic [ADDR_W-1:0] pc_q  = RESET_VEC;
  logic [CNT_W-1:0]  cnt_q = '0;
  logic [PTR_W-1:0]  top_q = '0;
  logic              ovf_q = 1'b0;
  logic              unf_q = 1'b0;

  logic [ADDR_W-1:0] pc_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [PTR_W-1:0]  top_d;
  logic              ovf_d;
  logic              unf_d;

  // top_q is the slot the next push writes; the live top entry sits one below it.
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic              push_en;
  logic [ADDR_W-1:0] pc_seq;
  logic [PTR_W-1:0]  top_m1;
  logic              is_empty;
  logic              is_full;

  assign pc_seq   = pc_q + StepV;
  assign top_m1   = top_q - PTR_W'(1);
  assign is_empty = (cnt_q == CntZero);
  assign is_full  = (cnt_q == CntFull);

  // Next-state selection by priority stall > ret > call > write > branch_rel > pc_inc.
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    push_en = 1'b0;
    // Clear first so a coincident error event below wins.
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    unf_d   = clr_err ? 1'b0 : unf_q;
    if (!stall) begin
      if (ret) begin
        if (!is_empty) begin
          pc_d  = ras_mem[top_m1];
          top_d = top_m1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pc_d  = pc_seq;
          unf_d = 1'b1;
        end
      end else if (call) begin
        push_en = 1'b1;
        pc_d    = wdata;
        top_d   = top_q + PTR_W'(1);
        // When full the push lands on the oldest slot and the count saturates.
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (write) begin
        pc_d = wdata;
      end else if (branch_rel) begin
        pc_d = pc_q + offset;
      end else if (pc_inc) begin
        pc_d = pc_seq;
      end
    end
  end

  // Control state with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage; contents are don't-care after reset, so no reset and no rst gating.
  always_ff @(posedge clk) begin
    if (push_en) begin
      ras_mem[top_q] <= pc_seq;
    end
  end

  assign pc_out    = pc_q;
  assign ras_empty = is_empty;
  assign ras_full  = is_full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: doc/pc_ras.md
PC_RAS -- requirements
Module: pc_ras

Interface
- REQ-001: Parameter ADDR_W, default 24, sets the program-counter and return-address width in bits.
- REQ-002: Parameter RESET_VEC, default 0, is the PC value loaded on reset.
- REQ-003: Parameter STEP, default 1, is the sequential increment.
- REQ-004: Parameter RAS_DEPTH, default 8 (power of two, minimum 2), is the number of return-address stack (RAS) entries.
- REQ-005: clk  in  1  sole clock; all state updates on the rising edge.
- REQ-006: rst  in  1  reset, synchronous and active-high.
- REQ-007: stall  in  1  freezes the PC and the RAS for the cycle.
- REQ-008: pc_inc  in  1  advances the PC by STEP.
- REQ-009: write  in  1  loads the PC from wdata (absolute jump).
- REQ-010: wdata  in  ADDR_W  jump/call target.
- REQ-011: branch_rel  in  1  adds offset to the PC.
- REQ-012: offset  in  ADDR_W  relative displacement, two's complement.
- REQ-013: call  in  1  pushes the return address and jumps to wdata.
- REQ-014: ret  in  1  pops the RAS into the PC.
- REQ-015: clr_err  in  1  clears the sticky error flags.
- REQ-016: pc_out  out  ADDR_W  current PC, driven directly from the register.
- REQ-017: ras_empty  out  1  high when the RAS count is 0.
- REQ-018: ras_full  out  1  high when the RAS count equals RAS_DEPTH.
- REQ-019: ras_ovf  out  1  sticky flag: a push occurred while the RAS was full.
- REQ-020: ras_unf  out  1  sticky flag: a pop occurred while the RAS was empty.

Function
- REQ-021: Exactly one command shall execute per cycle, chosen by fixed priority rst > stall > ret > call > write > branch_rel > pc_inc; lower-priority commands asserted in the same cycle are ignored.
- REQ-022: With no command asserted, the PC and the RAS shall hold.
- REQ-023: Command effects shall be visible on pc_out one cycle after the edge that samples them (1-cycle latency), with no combinational path from any input to pc_out.
- REQ-024: pc_inc shall load pc + STEP, modulo 2^ADDR_W; wrap from all-ones to 0 is legal and silent.
- REQ-025: write shall load wdata.
- REQ-026: branch_rel shall load pc + offset, modulo 2^ADDR_W, with offset sign-extended semantics (e.g. offset all-ones means pc - 1).
- REQ-027: call shall push pc + STEP (modulo) onto the RAS and load wdata into the PC in the same edge.
- REQ-028: call when full shall overwrite the oldest entry (circular), keep the count at RAS_DEPTH, set ras_ovf, and still perform the jump.
- REQ-029: ret when not empty shall load the top entry into the PC and decrement the count.
- REQ-030: ret when empty shall load pc + STEP, leave the count at 0, and set ras_unf.
- REQ-031: The RAS shall be a circular buffer with a top pointer of log2(RAS_DEPTH) bits and a count from 0 to RAS_DEPTH.
- REQ-032: After an overflow, pops shall return the most recent RAS_DEPTH return addresses in LIFO order.
- REQ-033: ras_empty and ras_full shall be registered-state decodes of the count, valid in the same cycle as pc_out.
- REQ-034: ras_ovf and ras_unf shall stay set until rst or clr_err.
- REQ-035: clr_err shall be honoured even during stall.
- REQ-036: If clr_err and a new error event coincide, the flag shall end up set.
- REQ-037: stall shall block all PC/RAS updates and suppress error-flag setting for that cycle.

Reset
- REQ-038: On a rising edge with rst=1: pc_out = RESET_VEC, RAS count = 0, top pointer = 0, ras_empty = 1, ras_full = 0, ras_ovf = 0, ras_unf = 0.
- REQ-039: rst shall override every other input in the same cycle, including mid call/ret sequences.
- REQ-040: RAS entry contents are don't-care after reset and shall never be observable while empty.
- REQ-041: Simulation initial values shall equal the reset values.

Verification
- REQ-042: Increment and wrap (ADDR_W=24, STEP=1): rst, then 3 cycles of pc_inc -> pc_out 1, 2, 3; write wdata=0xFFFFFF then pc_inc -> pc_out 0xFFFFFF then 0x000000.
- REQ-043: Priority: pc=0x10; write=1, wdata=0x200, pc_inc=1, branch_rel=1 in the same cycle -> pc=0x200; next cycle stall=1 with pc_inc=1 -> pc remains 0x200.
- REQ-044: Relative branch: pc=0x100; offset=0xFFFFF0 -> 0x0F0; then offset=0x000020 -> 0x110.
- REQ-045: Nested call/ret: pc=0x10; call 0x100; call 0x200; ret; ret -> pc 0x100, 0x200, 0x101, 0x11; ras_empty=1 at the end; no error flags set.
- REQ-046: Overflow/underflow (RAS_DEPTH=8): 9 calls from pc values 0..8 (each call lands at a new target, with write between calls as needed) -> ras_full=1, ras_ovf=1; then 8 rets return the latest 8 return addresses in LIFO order; a 9th ret -> pc+1, ras_unf=1; clr_err -> both flags 0.
- REQ-047: Reset mid-operation: after 3 calls, assert rst together with ret=1 -> pc=RESET_VEC, ras_empty=1, flags 0; a following ret -> ras_unf=1, pc=RESET_VEC+1.
